// File: rtl/tpu_pkg.sv
// Shared definitions for the NxN systolic matrix-multiply core:
// FSM state type, counter sizing helpers and accumulator saturation limits.
package tpu_pkg;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    COMPUTE,
    OUTPUT
  } state_t;

  // Width of a counter that indexes one NxN operand matrix.
  function automatic int cnt_width(input int n);
    return $clog2(n * n);
  endfunction

  // Skewed wavefront needs 3N-2 cycles to pass every k through every PE.
  function automatic int compute_cycles(input int n);
    return 3 * n - 2;
  endfunction

  function automatic longint acc_sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint acc_sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/tpu_pe.sv
// One output-stationary MAC cell: registered a/b pass-through, signed accumulate.
// Build with TPU_ACC_SAT_EN for sticky saturation instead of modulo wrap.
module tpu_pe
  import tpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [ACC_W-1:0]  acc
);

  logic [DATA_W-1:0]          a_reg, b_reg;
  logic [ACC_W-1:0]           acc_reg, acc_next;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W:0]      sum;

  // One guard bit above ACC_W exposes signed overflow of the accumulate.
  assign prod = $signed(a_in) * $signed(b_in);
  assign sum  = $signed({acc_reg[ACC_W-1], acc_reg}) + (ACC_W + 1)'(prod);

`ifdef TPU_ACC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(acc_sat_max(ACC_W));
  localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(acc_sat_min(ACC_W));

  logic sat_reg, sat_next;

  // Once clipped the cell holds its limit for the rest of the job.
  always_comb begin
    acc_next = sum[ACC_W-1:0];
    sat_next = sat_reg;
    if (sat_reg) begin
      acc_next = acc_reg;
    end else if (sum[ACC_W] != sum[ACC_W-1]) begin
      acc_next = sum[ACC_W] ? ACC_MIN : ACC_MAX;
      sat_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) sat_reg <= 1'b0;
    else            sat_reg <= sat_next;
  end
`else
  assign acc_next = sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc_reg <= '0;
    end else begin
      a_reg   <= a_in;
      b_reg   <= b_in;
      acc_reg <= acc_next;
    end
  end

  assign a_out = a_reg;
  assign b_out = b_reg;
  assign acc   = acc_reg;

endmodule

// File: rtl/tpu_core_nxn.sv
// NxN output-stationary systolic core: loads A then B as a byte stream, computes
// A x B (or A x B^T) with optional ReLU and streams C row-major. See TPU_ACC_SAT_EN in tpu_pe.
module tpu_core_nxn
  import tpu_pkg::*;
#(
  parameter int N      = 2,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              transpose,
  input  logic              activation,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int NN    = N * N;
  localparam int CNT_W = cnt_width(N);
  localparam int CCYC  = compute_cycles(N);
  localparam int CYC_W = $clog2(CCYC);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CYC_W-1:0]  cyc_reg;
  logic              transpose_reg, relu_reg;
  logic              out_valid_reg, done_reg;
  logic [ACC_W-1:0]  out_data_reg;
  logic [DATA_W-1:0] a_mem [NN];
  logic [DATA_W-1:0] b_mem [NN];
  logic [DATA_W-1:0] a_feed [N];
  logic [DATA_W-1:0] b_feed [N];
  logic [DATA_W-1:0] a_east [N][N];
  logic [DATA_W-1:0] b_south [N][N];
  logic [ACC_W-1:0]  acc_arr [NN];
  logic [ACC_W-1:0]  res [NN];
  logic [N-1:0]      unused_east, unused_south;
  logic              in_fire, out_fire, last_beat, last_cyc, pe_clr;

  assign in_ready  = (state_reg == LOAD_A) || (state_reg == LOAD_B);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_reg && out_ready;
  assign last_beat = (cnt_reg == CNT_W'(NN - 1));
  assign last_cyc  = (cyc_reg == CYC_W'(CCYC - 1));
  assign pe_clr    = (state_reg == LOAD_B) && in_fire && last_beat;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= LOAD_A;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LOAD_A:  if (in_fire && last_beat) state_next = LOAD_B;
      LOAD_B:  if (in_fire && last_beat) state_next = COMPUTE;
      COMPUTE: if (last_cyc) state_next = OUTPUT;
      OUTPUT:  if (out_fire && last_beat) state_next = LOAD_A;
      default: state_next = LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg       <= '0;
      cyc_reg       <= '0;
      transpose_reg <= 1'b0;
      relu_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      done_reg      <= 1'b0;
      for (int k = 0; k < NN; k++) begin
        a_mem[k] <= '0;
        b_mem[k] <= '0;
      end
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        LOAD_A, LOAD_B: begin
          if (in_fire) begin
            if (state_reg == LOAD_A) a_mem[cnt_reg] <= in_data;
            else                     b_mem[cnt_reg] <= in_data;
            if (state_reg == LOAD_A && cnt_reg == '0) begin
              transpose_reg <= transpose;
              relu_reg      <= activation;
            end
            cnt_reg <= last_beat ? '0 : cnt_reg + CNT_W'(1);
          end
        end
        COMPUTE: cyc_reg <= last_cyc ? '0 : cyc_reg + CYC_W'(1);
        OUTPUT: begin
          // First OUTPUT cycle only primes the result register.
          if (!out_valid_reg) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= res[cnt_reg];
          end else if (out_ready) begin
            if (last_beat) begin
              out_valid_reg <= 1'b0;
              done_reg      <= 1'b1;
              cnt_reg       <= '0;
            end else begin
              cnt_reg      <= cnt_reg + CNT_W'(1);
              out_data_reg <= res[cnt_reg + CNT_W'(1)];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Row i / column j see operand k at compute cycle i+k / j+k; zeros elsewhere.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_feed[i] = '0;
      b_feed[i] = '0;
      if (state_reg == COMPUTE && int'(cyc_reg) >= i && int'(cyc_reg) < i + N) begin
        a_feed[i] = a_mem[CNT_W'(i * N + int'(cyc_reg) - i)];
        b_feed[i] = transpose_reg ? b_mem[CNT_W'(i * N + int'(cyc_reg) - i)]
                                  : b_mem[CNT_W'((int'(cyc_reg) - i) * N + i)];
      end
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_row
      for (gj = 0; gj < N; gj++) begin : g_col
        logic [DATA_W-1:0] a_west, b_north;
        if (gj == 0) begin : g_wedge
          assign a_west = a_feed[gi];
        end else begin : g_winner
          assign a_west = a_east[gi][gj-1];
        end
        if (gi == 0) begin : g_nedge
          assign b_north = b_feed[gj];
        end else begin : g_ninner
          assign b_north = b_south[gi-1][gj];
        end
        tpu_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
          .clk   (clk),
          .rst   (rst),
          .clr   (pe_clr),
          .a_in  (a_west),
          .b_in  (b_north),
          .a_out (a_east[gi][gj]),
          .b_out (b_south[gi][gj]),
          .acc   (acc_arr[gi*N+gj])
        );
      end
      assign unused_east[gi]  = ^a_east[gi][N-1];
      assign unused_south[gi] = ^b_south[N-1][gi];
    end
    for (gi = 0; gi < NN; gi++) begin : g_res
      assign res[gi] = (relu_reg && acc_arr[gi][ACC_W-1]) ? '0 : acc_arr[gi];
    end
  endgenerate

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign done      = done_reg;
  assign busy      = !(state_reg == LOAD_A && cnt_reg == '0);

endmodule

// File: tb/tb_tpu_core_nxn.sv
// Directed bench for tpu_core_nxn (N=2): multiply, transpose, ReLU, overflow,
// random handshakes, back-to-back jobs and mid-job reset.
module tb_tpu_core_nxn;

  localparam int NN = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, transpose, activation;
  logic [7:0]  in_data;
  logic        out_valid, out_ready, busy, done;
  logic [15:0] out_data;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  tpu_core_nxn #(.N(2), .DATA_W(8), .ACC_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .transpose  (transpose),
    .activation (activation),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Streams A then B (byte k of vec is beat k). Mode pins flip after beat 0 when toggle is set.
  task automatic load_job(input logic [63:0] vec, input bit tr, input bit act,
                          input bit toggle, input int valid_pct);
    int  k = 0;
    int  guard = 0;
    bit  fire;
    while (k < 2 * NN && guard < 1000) begin
      @(negedge clk);
      in_valid   = ($urandom_range(99) < valid_pct);
      in_data    = vec[8*k +: 8];
      transpose  = (toggle && k > 0) ? ~tr : tr;
      activation = (toggle && k > 0) ? ~act : act;
      fire = in_valid && in_ready;
      @(posedge clk);
      if (fire) begin
        $display("in  beat %0d data %02h", k, vec[8*k +: 8]);
        k++;
      end
      guard++;
    end
    check("load_beats_accepted", k, 2 * NN);
  endtask

  // Drains NN results (element g of exp is [16g +: 16]) and checks latency, stalls and done.
  task automatic collect(input string tag, input logic [63:0] exp, input int ready_pct);
    int          got = 0;
    int          idx = 0;
    int          first_idx = -1;
    int          early_done = 0;
    bit          stall_prev = 0;
    logic [15:0] prev_data = '0;
    while (got < NN && idx < 2000) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (first_idx < 0 && out_valid) begin
        first_idx = idx;
        check({tag, "_latency"}, first_idx, 5);
      end
      if (stall_prev) begin
        check({tag, "_stall_valid"}, out_valid, 1'b1);
        check({tag, "_stall_data"}, out_data, prev_data);
      end
      if (done) early_done++;
      out_ready = ($urandom_range(99) < ready_pct);
      if (out_valid && out_ready) begin
        $display("out %s elem %0d data %04h", tag, got, out_data);
        check({tag, "_data"}, out_data, exp[16*got +: 16]);
        got++;
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      idx++;
    end
    check({tag, "_results_count"}, got, NN);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_done_pulse"}, done, 1'b1);
    check({tag, "_ready_in_done_cycle"}, in_ready, 1'b1);
    check({tag, "_valid_after_last"}, out_valid, 1'b0);
    @(negedge clk);
    check({tag, "_done_clears"}, done, 1'b0);
    check({tag, "_no_early_done"}, early_done, 0);
  endtask

  localparam logic [63:0] V_BASIC = 64'h0807060504030201;
  localparam logic [63:0] V_RELU  = 64'h03000002010000FF;
  localparam logic [63:0] V_OVF   = 64'h8080808080808080;
  localparam logic [63:0] E_BASIC = 64'h0032002B00160013;
  localparam logic [63:0] E_TRANS = 64'h0035002700170011;
  localparam logic [63:0] E_RELU1 = 64'h0003000000000000;
  localparam logic [63:0] E_RELU0 = 64'h000300000000FFFE;
`ifdef TPU_ACC_SAT_EN
  localparam logic [63:0] E_OVF   = 64'h7FFF7FFF7FFF7FFF;
`else
  localparam logic [63:0] E_OVF   = 64'h8000800080008000;
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    transpose = 1'b0; activation = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 16'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;

    load_job(V_BASIC, 1'b0, 1'b0, 1'b0, 100);
    collect("basic", E_BASIC, 100);

    load_job(V_BASIC, 1'b1, 1'b0, 1'b0, 100);
    collect("transpose", E_TRANS, 100);

    load_job(V_BASIC, 1'b1, 1'b0, 1'b1, 100);
    collect("transpose_toggle", E_TRANS, 100);

    load_job(V_RELU, 1'b0, 1'b1, 1'b0, 100);
    collect("relu_on", E_RELU1, 100);

    load_job(V_RELU, 1'b0, 1'b0, 1'b0, 100);
    collect("relu_off", E_RELU0, 100);

    load_job(V_OVF, 1'b0, 1'b0, 1'b0, 100);
    collect("overflow", E_OVF, 100);

    load_job(V_BASIC, 1'b0, 1'b0, 1'b0, 50);
    collect("random_hs", E_BASIC, 50);
    load_job(V_BASIC, 1'b1, 1'b0, 1'b0, 50);
    collect("random_hs_tr", E_TRANS, 50);

    // Abandon a job in COMPUTE.
    load_job(V_OVF, 1'b0, 1'b0, 1'b0, 100);
    @(negedge clk);
    in_valid = 1'b0;
    check("compute_busy", busy, 1'b1);
    check("compute_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    $display("reset asserted during compute");
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    rst = 1'b0;

    load_job(V_BASIC, 1'b0, 1'b0, 1'b0, 100);
    collect("after_reset", E_BASIC, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
